// File: rtl/serial_subtractor_pkg.sv
// +-----------------------------------------------------------------------+
// | serial_sub_pkg                                                        |
// | Shared types and defaults for the bit-serial subtractor.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// +-----------------------------------------------------------------------+
// | serial_subtractor_if                                                  |
// | Operand and result handshakes; ovf exists only with SERIAL_SUB_OVF_EN.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf
   );
`else
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
`endif

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +-----------------------------------------------------------------------+
// | full_subtractor                                                       |
// | One-bit subtract cell: difference = a - b - bin, borrow out.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic difference,
   output logic borrow
);

   assign difference = a ^ b ^ bin;
   assign borrow     = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +-----------------------------------------------------------------------+
// | serial_subtractor                                                     |
// | Bit-serial WIDTH-bit subtractor, LSB first through one full_subtractor|
// | Optional signed overflow flag: define SERIAL_SUB_OVF_EN.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic              clk,
   input  logic              rst_n,
   serial_subtractor_if.slave bus
);

   localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic               r_borrow;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_accept;
   logic               w_last;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_d;
   logic               w_bo;

   full_subtractor u_fs (
      .a          (r_a[0]),
      .b          (r_b[0]),
      .bin        (r_borrow),
      .difference (w_d),
      .borrow     (w_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_accept = 1'b1;
               w_next   = RUN;
            end
         end
         RUN: begin
            if (r_cnt == c_last) begin
               w_last = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_a      <= bus.a;
         r_b      <= bus.b;
         r_borrow <= bus.bin;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_res    <= {w_d, r_res[WIDTH-1:1]};
         r_borrow <= w_bo;
         r_cnt    <= r_cnt + c_cnt_one;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;

   // On the last RUN cycle the shift-register LSBs are the original operand MSBs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.diff      = r_res;
   assign bus.bout      = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +-----------------------------------------------------------------------+
// | tb_serial_subtractor                                                  |
// | Directed and random-operand bench with an arithmetic reference model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   exp_t q[$];

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bi);
      exp_t e;
      int   d;
      int   s;
      d      = int'(a) - int'(b) - int'(bi);
      s      = int'($signed(a)) - int'($signed(b)) - int'(bi);
      e.diff = WIDTH'(d);
      e.bout = (d < 0);
      e.ovf  = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
      return e;
   endfunction

   // Scoreboard: every cycle out_valid is high the held result must match the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               check("sb_unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
               check("sb_diff", 64'(bus.diff), 64'(q[0].diff));
               check("sb_bout", 64'(bus.bout), 64'(q[0].bout));
`ifdef SERIAL_SUB_OVF_EN
               check("sb_ovf", 64'(bus.ovf), 64'(q[0].ovf));
`endif
               check("sb_in_ready_in_done", 64'(bus.in_ready), 64'd0);
               if (bus.out_ready) void'(q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.bin));
      end
   end

   task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibin,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                        input int hold);
      int edges;
      bus.a         = ia;
      bus.b         = ib;
      bus.bin       = ibin;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      edges = 0;
      while (!bus.in_ready && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      check("accept_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      edges = 1;
      while (!bus.out_valid && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      check("latency_edges", 64'(edges), 64'(WIDTH + 1));
      check("lit_diff", 64'(bus.diff), 64'(ed));
      check("lit_bout", 64'(bus.bout), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
      check("lit_ovf", 64'(bus.ovf), 64'(eo));
`else
      if (eo) begin end
`endif
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            bus.a        = ~ia;
            bus.b        = ib + 8'd1;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_diff_held", 64'(bus.diff), 64'(ed));
         check("bp_bout_held", 64'(bus.bout), 64'(eb));
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("post_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int last_acc;
      int waited;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_diff", 64'(bus.diff), 64'd0);
      check("rst_bout", 64'(bus.bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
      do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
      do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_op(8'hC3, 8'h45, 1'b1, 8'h7D, 1'b0, 1'b1, 5);

      // Operands pulsed during DONE must have been dropped.
      repeat (12) @(posedge clk);
      #1;
      check("bp_dropped_out_valid", 64'(bus.out_valid), 64'd0);
      check("bp_dropped_in_ready", 64'(bus.in_ready), 64'd1);

      // Reset after three bits of an operation.
      bus.a        = 8'hAA;
      bus.b        = 8'h11;
      bus.bin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_run_busy", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_rst_diff", 64'(bus.diff), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

      do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
      do_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 0);

      // Back-to-back random operations, both handshakes held high.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      last_acc      = 0;
      for (int k = 0; k < 100; k++) begin
         bus.a   = WIDTH'($urandom);
         bus.b   = WIDTH'($urandom);
         bus.bin = 1'($urandom_range(1));
         waited  = 0;
         while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
         end
         check("b2b_ready", 64'(bus.in_ready), 64'd1);
         @(posedge clk); #1;
         if (k > 0) check("b2b_throughput", 64'(cyc - last_acc), 64'(WIDTH + 2));
         last_acc = cyc;
      end
      bus.in_valid = 1'b0;
      waited = 0;
      while ((q.size() != 0 || bus.out_valid) && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check("b2b_drained", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
